// File: rtl/axis_frame_capture_if.sv
// rtl/axis_frame_capture_if.sv - AXI-Stream beat bundle feeding the frame capture buffer
interface axis_frame_capture_if #(
  parameter int WIDTH    = 32,
  parameter int USER_WID = 8
) ();
  logic [WIDTH-1:0]    tdata;
  logic                tvalid;
  logic                tready;
  logic                tlast;
  logic [USER_WID-1:0] tuser;

  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_frame_capture.sv
// rtl/axis_frame_capture.sv - frame-aware AXI-Stream capture RAM with registered read-back port
module axis_frame_capture #(
  parameter int WIDTH       = 32,
  parameter int USER_WID    = 8,
  parameter int DEPTH       = 2048,
  parameter int ALIGN       = 1,
  parameter int STOP_FRAMES = 0,
  parameter int AW          = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      arm,
  axis_frame_capture_if.slave       s_axis,
  output logic                      busy,
  output logic                      done,
  output logic                      full,
  output logic [AW:0]               wr_count,
  output logic [15:0]               frame_count,
  input  logic [AW-1:0]             rd_addr,
  output logic [WIDTH+USER_WID:0]   rd_data
);
  localparam int DW       = WIDTH + USER_WID + 1;
  localparam int DEPTH_M1 = DEPTH - 1;
  localparam logic [AW:0] C_FULL = DEPTH[AW:0];
  localparam logic [AW:0] C_LAST = DEPTH_M1[AW:0];
  localparam logic [15:0] C_STOP = STOP_FRAMES[15:0];

  typedef enum logic [1:0] {S_IDLE, S_WAIT_ALIGN, S_CAPTURE, S_DONE} state_t;
  localparam state_t C_ARM_STATE = (ALIGN != 0) ? S_WAIT_ALIGN : S_CAPTURE;

  state_t          r_state;
  state_t          w_next;
  logic            r_tready;
  logic [AW:0]     r_wr_count;
  logic [15:0]     r_frame_count;
  logic [DW-1:0]   r_mem [DEPTH];
  logic [DW-1:0]   r_rd_data;
  logic            w_acc;
  logic            w_wr_en;
  logic            w_last_entry;
  logic            w_stop_hit;

  assign w_acc        = s_axis.tvalid & r_tready;
  assign w_last_entry = (r_wr_count == C_LAST);
  // Only the tlast that completes the N-th frame ends a frame-limited capture.
  assign w_stop_hit   = (STOP_FRAMES != 0) && s_axis.tlast && ((r_frame_count + 16'd1) == C_STOP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (arm) begin
      w_next = C_ARM_STATE;
    end else begin
      case (r_state)
        S_WAIT_ALIGN: if (w_acc && s_axis.tlast) w_next = S_CAPTURE;
        S_CAPTURE:    if (w_acc && (w_last_entry || w_stop_hit)) w_next = S_DONE;
        default:      w_next = r_state;
      endcase
    end
  end

  always_comb begin
    busy    = (r_state == S_WAIT_ALIGN) || (r_state == S_CAPTURE);
    done    = (r_state == S_DONE);
    // A beat arriving alongside arm belongs to the old session and is dropped.
    w_wr_en = (r_state == S_CAPTURE) && w_acc && !arm;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tready <= 1'b0;
    end else begin
      r_tready <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_count    <= '0;
      r_frame_count <= '0;
    end else if (arm) begin
      r_wr_count    <= '0;
      r_frame_count <= '0;
    end else if (w_wr_en) begin
      r_wr_count <= r_wr_count + 1'b1;
      if (s_axis.tlast && (r_frame_count != 16'hFFFF)) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_count[AW-1:0]] <= {s_axis.tuser, s_axis.tlast, s_axis.tdata};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[rd_addr];
    end
  end

  assign s_axis.tready = r_tready;
  assign full          = (r_wr_count == C_FULL);
  assign wr_count      = r_wr_count;
  assign frame_count   = r_frame_count;
  assign rd_data       = r_rd_data;
endmodule

// File: tb/tb_axis_frame_capture.sv
// tb/tb_axis_frame_capture.sv - two capture configurations against a queue-style reference model
module tb_axis_frame_capture;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arm = 1'b0;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;
  logic [31:0] tdata = '0;
  logic [7:0]  tuser = '0;
  logic [5:0]  rd_addr = '0;

  always #5 clk = ~clk;

  axis_frame_capture_if #(.WIDTH(32), .USER_WID(8)) if_a ();
  axis_frame_capture_if #(.WIDTH(32), .USER_WID(8)) if_b ();
  assign if_a.tdata = tdata;  assign if_a.tvalid = tvalid;
  assign if_a.tlast = tlast;  assign if_a.tuser  = tuser;
  assign if_b.tdata = tdata;  assign if_b.tvalid = tvalid;
  assign if_b.tlast = tlast;  assign if_b.tuser  = tuser;

  logic        busy_a, done_a, full_a, busy_b, done_b, full_b;
  logic [4:0]  wr_a;
  logic [6:0]  wr_b;
  logic [15:0] fc_a, fc_b;
  logic [40:0] rd_a, rd_b;

  axis_frame_capture #(.WIDTH(32), .USER_WID(8), .DEPTH(16), .ALIGN(0), .STOP_FRAMES(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .arm(arm), .s_axis(if_a.slave),
    .busy(busy_a), .done(done_a), .full(full_a), .wr_count(wr_a), .frame_count(fc_a),
    .rd_addr(rd_addr[3:0]), .rd_data(rd_a));

  axis_frame_capture #(.WIDTH(32), .USER_WID(8), .DEPTH(64), .ALIGN(1), .STOP_FRAMES(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .arm(arm), .s_axis(if_b.slave),
    .busy(busy_b), .done(done_b), .full(full_b), .wr_count(wr_b), .frame_count(fc_b),
    .rd_addr(rd_addr), .rd_data(rd_b));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a capture session is a list of stored beats plus a "stopped" flag.
  int          P_DEPTH [2] = '{16, 64};
  int          P_ALIGN [2] = '{0, 1};
  int          P_STOP  [2] = '{0, 2};
  logic [40:0] m_mem   [2][64];
  bit          m_vld   [2][64];
  int          m_cnt   [2];
  int          m_frames[2];
  bit          m_armed [2];
  bit          m_aligned[2];
  bit          m_ended [2];
  logic [40:0] m_rd    [2];
  bit          m_rd_ok [2];
  bit          m_ready = 1'b0;

  function automatic void model_step(int k);
    int a;
    a = (k == 0) ? int'(rd_addr[3:0]) : int'(rd_addr);
    m_rd_ok[k] = m_vld[k][a];
    m_rd[k]    = m_mem[k][a];
    if (arm) begin
      m_armed[k] = 1; m_aligned[k] = (P_ALIGN[k] == 0);
      m_cnt[k] = 0; m_frames[k] = 0; m_ended[k] = 0;
    end else if (m_armed[k] && !m_ended[k] && tvalid && m_ready) begin
      if (!m_aligned[k]) begin
        m_aligned[k] = tlast;
      end else begin
        m_mem[k][m_cnt[k]] = {tuser, tlast, tdata};
        m_vld[k][m_cnt[k]] = 1;
        m_cnt[k]++;
        if (tlast && m_frames[k] < 65535) m_frames[k]++;
        if (m_cnt[k] == P_DEPTH[k] || (P_STOP[k] > 0 && tlast && m_frames[k] == P_STOP[k]))
          m_ended[k] = 1;
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready = 0;
      for (int k = 0; k < 2; k++) begin
        m_cnt[k] = 0; m_frames[k] = 0; m_armed[k] = 0; m_aligned[k] = 0;
        m_ended[k] = 0; m_rd[k] = '0; m_rd_ok[k] = 1;
      end
    end else begin
      for (int k = 0; k < 2; k++) model_step(k);
      m_ready = 1;
    end
  end

  always @(negedge clk) begin
    chk("a_tready", if_a.tready, m_ready);
    chk("a_busy", busy_a, m_armed[0] && !m_ended[0]);
    chk("a_done", done_a, m_ended[0]);
    chk("a_full", full_a, m_cnt[0] == P_DEPTH[0]);
    chk("a_wr_count", wr_a, m_cnt[0]);
    chk("a_frame_count", fc_a, m_frames[0]);
    if (m_rd_ok[0]) chk("a_rd_data", rd_a, m_rd[0]);
    chk("b_tready", if_b.tready, m_ready);
    chk("b_busy", busy_b, m_armed[1] && !m_ended[1]);
    chk("b_done", done_b, m_ended[1]);
    chk("b_full", full_b, m_cnt[1] == P_DEPTH[1]);
    chk("b_wr_count", wr_b, m_cnt[1]);
    chk("b_frame_count", fc_b, m_frames[1]);
    if (m_rd_ok[1]) chk("b_rd_data", rd_b, m_rd[1]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int k);
    tvalid = 1; tdata = k; tuser = k[7:0]; tlast = (k % 8 == 7);
    tick();
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_tready", if_a.tready, 0);
    chk("rst_busy", busy_b, 0);
    chk("rst_rd_data", rd_a, 0);
    rst_n = 1;
    tick();

    arm = 1; tick(); arm = 0;
    for (int k = 0; k < 40; k++) beat(k);
    tvalid = 0; tlast = 0;
    chk("t1_a_wr_count", wr_a, 16);
    chk("t1_a_full", full_a, 1);
    chk("t1_a_done", done_a, 1);
    chk("t3_b_wr_count", wr_b, 16);
    chk("t3_b_done", done_b, 1);
    chk("t3_b_full", full_b, 0);
    chk("t3_b_frames", fc_b, 2);
    rd_addr = 5; tick();
    chk("t1_a_rd5", rd_a[31:0], 5);
    rd_addr = 0; tick();
    chk("t2_b_first", rd_b[31:0], 8);
    rd_addr = 7; tick();
    chk("t2_b_tlast7", rd_b[32], 1);

    for (int i = 0; i < 800; i++) begin
      arm     = ($urandom_range(0, 49) == 0);
      tvalid  = ($urandom_range(0, 2) != 0);
      tlast   = ($urandom_range(0, 5) == 0);
      tdata   = $urandom;
      tuser   = 8'(i);
      rd_addr = 6'($urandom);
      tick();
    end
    arm = 0; tvalid = 0; tlast = 0;

    arm = 1; tick(); arm = 0;
    for (int k = 100; k < 109; k++) beat(k);
    chk("t5_a_wr9", wr_a, 9);
    arm = 1; beat(109); arm = 0;
    chk("t5_a_rearm", wr_a, 0);
    beat(110);
    tvalid = 0; rd_addr = 0; tick();
    chk("t5_a_first", rd_a[31:0], 110);

    arm = 1; tick(); arm = 0;
    for (int k = 200; k < 206; k++) beat(k);
    @(negedge clk); #2;
    rst_n = 0; #1;
    chk("t6_tready", if_a.tready, 0);
    chk("t6_busy", busy_a, 0);
    chk("t6_wr_count", wr_a, 0);
    chk("t6_frames", fc_b, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    for (int k = 300; k < 310; k++) beat(k);
    tvalid = 0; tick();
    chk("t6_a_idle_wr", wr_a, 0);
    chk("t6_b_idle_busy", busy_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
